// File: rtl/histogram_feeder.sv
// Per-row sample histogram with a frame-synchronous flush into the visualizer row RAM.
// Bars are written in ascending row order; bins can optionally clear as they are read out.
//
// state | meaning
// ACCUM | collecting samples, waiting for frame_tick_in
// FLUSH | emitting one row per cycle, index 0..SCREEN_HEIGHT-1
module histogram_feeder #(
   parameter int SCREEN_HEIGHT = 42,
   parameter int MAX_BAR       = 76,
   parameter int COUNT_WIDTH   = 16,
   parameter int SHIFT         = 0,
   parameter int AUTO_CLEAR    = 1
) (
   input  logic                             pixel_clk_in,
   input  logic                             rst_n_in,
   input  logic                             sample_valid_in,
   input  logic [$clog2(SCREEN_HEIGHT)-1:0] sample_bin_in,
   input  logic                             frame_tick_in,
   input  logic                             clear_in,
   output logic                             tg_write_en,
   output logic [$clog2(SCREEN_HEIGHT)-1:0] tg_addr,
   output logic [31:0]                      tg_input,
   output logic                             busy_out,
   output logic                             overrun_out,
   output logic [15:0]                      drop_count_out
);

   localparam int                 BW         = $clog2(SCREEN_HEIGHT);
   localparam logic [BW-1:0]      LP_LAST    = BW'(SCREEN_HEIGHT - 1);
   localparam logic [COUNT_WIDTH-1:0] LP_CNT_MAX = '1;
   localparam logic [31:0]        LP_MAX_BAR = 32'(MAX_BAR);

   typedef enum logic {ACCUM, FLUSH} state_t;

   state_t                 r_state, w_state_nxt;
   logic [BW-1:0]          r_idx, w_idx_nxt;
   logic [COUNT_WIDTH-1:0] r_cnt      [SCREEN_HEIGHT];
   logic [COUNT_WIDTH-1:0] w_cnt_nxt  [SCREEN_HEIGHT];
   logic [1:0]             r_rst_sync;
   logic                   w_rst_n;
   logic                   w_capture;
   logic                   w_drop;
   logic [COUNT_WIDTH-1:0] w_cap_val;
   logic [31:0]            w_shifted;
   logic [31:0]            w_bar;

   // Assertion is immediate; release is retimed to the clock.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_rst_sync <= 2'b00;
      else           r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_capture   = 1'b0;
      case (r_state)
         ACCUM: begin
            if (frame_tick_in) begin
               w_state_nxt = FLUSH;
               w_idx_nxt   = '0;
            end
         end
         FLUSH: begin
            w_capture = 1'b1;
            if (r_idx == LP_LAST) begin
               w_state_nxt = ACCUM;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge pixel_clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= ACCUM;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   assign w_cap_val = r_cnt[r_idx];
   assign w_shifted = 32'(w_cap_val >> SHIFT);
   assign w_bar     = (w_shifted > LP_MAX_BAR) ? LP_MAX_BAR : w_shifted;
   assign w_drop    = sample_valid_in && ({1'b0, sample_bin_in} >= (BW+1)'(SCREEN_HEIGHT));

   // Capture-clear happens before the increment so a colliding sample lands in the new frame.
   always_comb begin
      for (int j = 0; j < SCREEN_HEIGHT; j++) begin
         w_cnt_nxt[j] = r_cnt[j];
         if ((AUTO_CLEAR != 0) && w_capture && (r_idx == BW'(j)))
            w_cnt_nxt[j] = '0;
         if (sample_valid_in && (sample_bin_in == BW'(j)) && (w_cnt_nxt[j] != LP_CNT_MAX))
            w_cnt_nxt[j] = w_cnt_nxt[j] + 1'b1;
         if (clear_in)
            w_cnt_nxt[j] = '0;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int j = 0; j < SCREEN_HEIGHT; j++) r_cnt[j] <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         tg_write_en    <= 1'b0;
         tg_addr        <= '0;
         tg_input       <= '0;
         busy_out       <= 1'b0;
         overrun_out    <= 1'b0;
         drop_count_out <= '0;
      end else begin
         tg_write_en <= w_capture;
         tg_addr     <= w_capture ? r_idx : '0;
         tg_input    <= w_capture ? w_bar : '0;
         busy_out    <= (w_state_nxt == FLUSH);
         overrun_out <= (r_state == FLUSH) && frame_tick_in;
         if (w_drop && (drop_count_out != 16'hFFFF))
            drop_count_out <= drop_count_out + 16'd1;
      end
   end

endmodule

// File: tb/tb_histogram_feeder.sv
// Bench for histogram_feeder: frame vectors from a table, a write scoreboard,
// and hand-built sequences for collision, overrun, clear and reset mid-flush.
module tb_histogram_feeder;

   localparam int H  = 42;
   localparam int BW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          valid = 1'b0, tick = 1'b0, clear = 1'b0;
   logic [BW-1:0] bin = '0;
   logic          we, busy, ovr;
   logic [BW-1:0] addr;
   logic [31:0]   data;
   logic [15:0]   drop;

   logic          s2_valid = 1'b0, s2_tick = 1'b0, s2_clear = 1'b0;
   logic [BW-1:0] s2_bin = '0;
   logic          s2_we, s2_busy, s2_ovr;
   logic [BW-1:0] s2_addr;
   logic [31:0]   s2_data;
   logic [15:0]   s2_drop;

   histogram_feeder dut (
      .pixel_clk_in(clk), .rst_n_in(rst_n), .sample_valid_in(valid), .sample_bin_in(bin),
      .frame_tick_in(tick), .clear_in(clear), .tg_write_en(we), .tg_addr(addr),
      .tg_input(data), .busy_out(busy), .overrun_out(ovr), .drop_count_out(drop));

   histogram_feeder #(.SHIFT(2)) dut_s2 (
      .pixel_clk_in(clk), .rst_n_in(rst_n), .sample_valid_in(s2_valid), .sample_bin_in(s2_bin),
      .frame_tick_in(s2_tick), .clear_in(s2_clear), .tg_write_en(s2_we), .tg_addr(s2_addr),
      .tg_input(s2_data), .busy_out(s2_busy), .overrun_out(s2_ovr), .drop_count_out(s2_drop));

   always #5 clk = ~clk;

   typedef struct {
      int bin_a; int n_a; int bin_b; int n_b; int exp_a; int exp_b; int exp_drop;
   } vec_t;

   typedef struct packed {
      logic [BW-1:0] addr;
      logic [31:0]   data;
   } sb_t;

   vec_t tbl [5];
   sb_t  sb_q [$];
   sb_t  m_e;
   int   exp_bar [H];
   int   e2 [H];
   int   n_chk = 0, n_fail = 0;
   int   wr_cnt, busy_cnt, ovr_cnt, first_wr, last_wr;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (we) begin
         n_chk++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_write: addr %0d data %0d, none expected", addr, data);
         end else begin
            m_e = sb_q.pop_front();
            if (addr !== m_e.addr || data !== m_e.data) begin
               n_fail++;
               $display("FAIL sb_write: got addr %0d data %0d, expected addr %0d data %0d",
                        addr, data, m_e.addr, m_e.data);
            end
         end
      end else if (addr !== '0 || data !== '0) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_outputs: got addr %0d data %0d, expected 0 0", addr, data);
      end
   end

   task automatic send(input int sel, input int b, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sel == 0) begin valid = 1'b1; bin = BW'(b); end
         else begin s2_valid = 1'b1; s2_bin = BW'(b); end
         if (i % 8 == 7) begin
            @(negedge clk);
            valid = 1'b0; s2_valid = 1'b0;
         end
      end
      @(negedge clk);
      valid = 1'b0; s2_valid = 1'b0;
   endtask

   task automatic clear_exp();
      for (int a = 0; a < H; a++) exp_bar[a] = 0;
   endtask

   task automatic push_expected();
      sb_t t;
      for (int a = 0; a < H; a++) begin
         t.addr = BW'(a);
         t.data = 32'(exp_bar[a]);
         sb_q.push_back(t);
      end
   endtask

   // k counts negedges after the edge that samples the tick; state index during k is k-1.
   task automatic run_flush(input int ovr_at, input int smp_at, input int smp_bin,
                            input int clr_at, input int rst_at);
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      wr_cnt = 0; busy_cnt = 0; ovr_cnt = 0; first_wr = 0; last_wr = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (we) begin
            wr_cnt++;
            if (first_wr == 0) first_wr = k;
            last_wr = k;
         end
         if (busy) busy_cnt++;
         if (ovr) ovr_cnt++;
         tick = 1'b0; valid = 1'b0; clear = 1'b0;
         if (k == ovr_at) tick = 1'b1;
         if (k == smp_at) begin valid = 1'b1; bin = BW'(smp_bin); end
         if (k == clr_at) clear = 1'b1;
         if (k == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_we_immediate", we, 0);
            chk("rst_busy_immediate", busy, 0);
            chk("rst_addr_immediate", addr, 0);
         end
         if (rst_at > 0 && k == rst_at + 4) rst_n = 1'b1;
      end
   endtask

   task automatic chk_nominal(input int exp_ovr);
      chk("flush_writes", wr_cnt, H);
      chk("flush_busy_cycles", busy_cnt, H);
      chk("first_write_latency", first_wr, 2);
      chk("write_run_contiguous", last_wr - first_wr + 1, H);
      chk("overrun_pulses", ovr_cnt, exp_ovr);
      chk("sb_drained", sb_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int n2;
      tbl[0] = '{3, 5, 0, 100, 5, 76, 0};
      tbl[1] = '{45, 3, 0, 0, 0, 0, 3};
      tbl[2] = '{41, 76, 40, 75, 76, 75, 3};
      tbl[3] = '{1, 77, 42, 1, 76, 0, 4};
      tbl[4] = '{63, 2, 2, 1, 0, 1, 6};

      #1 rst_n = 1'b0;
      #2;
      chk("reset_we", we, 0);
      chk("reset_addr", addr, 0);
      chk("reset_data", data, 0);
      chk("reset_busy", busy, 0);
      chk("reset_overrun", ovr, 0);
      chk("reset_drop", drop, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         send(0, tbl[v].bin_a, tbl[v].n_a);
         send(0, tbl[v].bin_b, tbl[v].n_b);
         chk("drop_count", drop, tbl[v].exp_drop);
         clear_exp();
         if (tbl[v].bin_a < H) exp_bar[tbl[v].bin_a] = tbl[v].exp_a;
         if (tbl[v].bin_b < H) exp_bar[tbl[v].bin_b] = tbl[v].exp_b;
         push_expected();
         run_flush(-1, -1, 0, -1, -1);
         chk_nominal(0);
      end

      // sample to bin 10 in the cycle bin 10 is captured
      send(0, 10, 7);
      clear_exp(); exp_bar[10] = 7; push_expected();
      run_flush(-1, 11, 10, -1, -1);
      chk_nominal(0);
      clear_exp(); exp_bar[10] = 1; push_expected();
      run_flush(-1, -1, 0, -1, -1);
      chk_nominal(0);

      // second tick at flush index 20
      send(0, 20, 3);
      clear_exp(); exp_bar[20] = 3; push_expected();
      run_flush(21, -1, 0, -1, -1);
      chk_nominal(1);

      // clear wins over a same-cycle increment
      send(0, 7, 4);
      @(negedge clk);
      valid = 1'b1; bin = BW'(7); clear = 1'b1;
      @(negedge clk);
      valid = 1'b0; clear = 1'b0;
      clear_exp(); push_expected();
      run_flush(-1, -1, 0, -1, -1);
      chk_nominal(0);

      // clear at flush index 30: earlier rows keep data, later rows read 0
      send(0, 5, 6);
      send(0, 35, 9);
      clear_exp(); exp_bar[5] = 6; push_expected();
      run_flush(-1, -1, 0, 31, -1);
      chk_nominal(0);

      // reset at flush index 15
      send(0, 12, 2);
      send(0, 30, 5);
      clear_exp(); exp_bar[12] = 2; exp_bar[30] = 5; push_expected();
      run_flush(-1, -1, 0, -1, 16);
      chk("rst_writes_before_abort", wr_cnt, 15);
      chk("rst_busy_cycles", busy_cnt, 16);
      chk("rst_sb_left", sb_q.size(), H - 15);
      chk("rst_overrun", ovr_cnt, 0);
      chk("rst_drop_cleared", drop, 0);
      sb_q.delete();
      clear_exp(); push_expected();
      run_flush(-1, -1, 0, -1, -1);
      chk_nominal(0);

      // SHIFT=2 instance
      send(1, 5, 13);
      send(1, 6, 4);
      send(1, 7, 3);
      send(1, 0, 400);
      for (int a = 0; a < H; a++) e2[a] = 0;
      e2[0] = 76; e2[5] = 3; e2[6] = 1; e2[7] = 0;
      @(negedge clk);
      s2_tick = 1'b1;
      @(negedge clk);
      s2_tick = 1'b0;
      n2 = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (s2_we) begin
            if (n2 < H) begin
               chk("s2_addr", s2_addr, n2);
               chk("s2_data", s2_data, e2[n2]);
            end else begin
               chk("s2_extra_write", 1, 0);
            end
            n2++;
         end
      end
      chk("s2_writes", n2, H);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
